// File: rtl/conv_param.sv
// Streaming 1-D convolution: loads an N-word vector and an M-tap filter, then emits
// the N-M+1 valid-mode results, P lanes at a time, saturated to T bits.
module conv_param #(
    parameter int T    = 20,
    parameter int N    = 20,
    parameter int M    = 13,
    parameter int P    = 2,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [T-1:0]        s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    input  logic [T-1:0]        s_data_in_f,
    input  logic                s_valid_f,
    output logic                s_ready_f,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);
    localparam int AW = 2*T + $clog2(M);
    localparam int XW = $clog2(N+1);
    localparam int XI = $clog2(N);
    localparam int FW = $clog2(M+1);
    localparam int FI = $clog2(M);
    localparam int LW = (P > 1) ? $clog2(P) : 1;

    localparam logic [XW-1:0] N_CNT  = XW'(N);
    localparam logic [XW-1:0] N_LAST = XW'(N-1);
    localparam logic [XW-1:0] LAST_I = XW'(N-M);
    localparam logic [XW-1:0] P_STEP = XW'(P);
    localparam logic [FW-1:0] M_CNT  = FW'(M);
    localparam logic [FW-1:0] M_LAST = FW'(M-1);
    localparam logic [LW-1:0] LANE_MAX = LW'(P-1);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
    state_t state;

    logic signed [T-1:0]   x_mem [N];
    logic signed [T-1:0]   f_mem [M];
    logic [XW-1:0]         x_cnt, base, out_i;
    logic [FW-1:0]         f_cnt, tap;
    logic [LW-1:0]         lane;
    logic signed [AW-1:0]  acc [P];
    logic signed [T-1:0]   res [P];
    logic [XW:0]           idx [P];
    logic signed [2*T-1:0] prod [P];
    logic x_fire, f_fire, x_done, f_done, last_lane, last_group;

    // Readies are combinational so both streams accept data in the very first cycle out of reset.
    assign s_ready_x = !reset && (state == LOAD) && (x_cnt < N_CNT);
    assign s_ready_f = !reset && (state == LOAD) && (f_cnt < M_CNT);
    assign x_fire    = s_valid_x && s_ready_x;
    assign f_fire    = s_valid_f && s_ready_f;
    assign x_done    = (x_cnt == N_CNT) || (x_fire && (x_cnt == N_LAST));
    assign f_done    = (f_cnt == M_CNT) || (f_fire && (f_cnt == M_LAST));

    assign out_i      = base + XW'(lane);
    assign last_group = (out_i == LAST_I);
    assign last_lane  = last_group || (lane == LANE_MAX);

    // Lanes past the end of the vector (inactive tail of the last group) contribute zero.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            idx[k]  = {1'b0, base} + (XW+1)'(k) + (XW+1)'(tap);
            prod[k] = '0;
            if (idx[k] < (XW+1)'(N))
                prod[k] = (2*T)'(x_mem[idx[k][XI-1:0]]) * (2*T)'(f_mem[tap[FI-1:0]]);
        end
    end

    function automatic logic signed [T-1:0] saturate(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] hi, lo;
        logic signed [T-1:0]  r;
        hi = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
        lo = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};
        if (a > hi)      r = hi[T-1:0];
        else if (a < lo) r = lo[T-1:0];
        else             r = a[T-1:0];
        if (RELU != 0 && r[T-1]) r = '0;
        return r;
    endfunction

    // NOTE: storage arrays carry no reset; the word counters alone define what is valid,
    // which keeps the arrays as plain RAM-style registers.
    always_ff @(posedge clk) begin
        if (x_fire) x_mem[x_cnt[XI-1:0]] <= s_data_in_x;
        if (f_fire) f_mem[f_cnt[FI-1:0]] <= s_data_in_f;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            x_cnt        <= '0;
            f_cnt        <= '0;
            tap          <= '0;
            base         <= '0;
            lane         <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
            for (int k = 0; k < P; k++) begin
                acc[k] <= '0;
                res[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (x_fire) x_cnt <= x_cnt + XW'(1);
                    if (f_fire) f_cnt <= f_cnt + FW'(1);
                    if (x_done && f_done) begin
                        tap   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (tap == M_CNT) begin
                        for (int k = 0; k < P; k++) res[k] <= saturate(acc[k]);
                        m_data_out_y <= saturate(acc[0]);
                        m_valid_y    <= 1'b1;
                        lane         <= '0;
                        tap          <= '0;
                        state        <= OUTPUT;
                    end else begin
                        for (int k = 0; k < P; k++)
                            acc[k] <= (tap == '0) ? AW'(prod[k]) : acc[k] + AW'(prod[k]);
                        tap <= tap + FW'(1);
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        if (last_lane) begin
                            m_valid_y <= 1'b0;
                            if (last_group) begin
                                x_cnt <= '0;
                                f_cnt <= '0;
                                base  <= '0;
                                state <= LOAD;
                            end else begin
                                base  <= base + P_STEP;
                                state <= COMPUTE;
                            end
                        end else begin
                            lane         <= lane + LW'(1);
                            m_data_out_y <= res[lane + LW'(1)];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_param.sv
// Scoreboard bench for conv_param: default, RELU=1 and P=3 instances, directed vectors,
// random stream interleaving and output back-pressure, and a mid-compute reset.
module tb_conv_param;
    localparam int T    = 20;
    localparam int N    = 20;
    localparam int M    = 13;
    localparam int NOUT = N - M + 1;
    localparam int YMAX = 524287;
    localparam int YMIN = -524288;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic signed [T-1:0] dx [3];
    logic signed [T-1:0] df [3];
    logic signed [T-1:0] y  [3];
    logic vx [3], vf [3], rx [3], rf [3], vy [3], ry [3];

    int xv [N];
    int fv [M];
    int q [$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int t0, tl;

    always @(posedge clk) cyc <= cyc + 1;

    conv_param u_dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx[0]), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
        .s_data_in_f(df[0]), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
        .m_data_out_y(y[0]), .m_valid_y(vy[0]), .m_ready_y(ry[0])
    );

    conv_param #(.RELU(1)) u_relu (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx[1]), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
        .s_data_in_f(df[1]), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
        .m_data_out_y(y[1]), .m_valid_y(vy[1]), .m_ready_y(ry[1])
    );

    conv_param #(.P(3)) u_p3 (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx[2]), .s_valid_x(vx[2]), .s_ready_x(rx[2]),
        .s_data_in_f(df[2]), .s_valid_f(vf[2]), .s_ready_f(rf[2]),
        .m_data_out_y(y[2]), .m_valid_y(vy[2]), .m_ready_y(ry[2])
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: exact 64-bit dot product, then clamp, then optional ReLU.
    function automatic int model(input int i, input bit relu);
        longint s = 0;
        for (int j = 0; j < M; j++) s += longint'(xv[i+j]) * longint'(fv[j]);
        if (s > YMAX) s = YMAX;
        else if (s < YMIN) s = YMIN;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic set_const(input int xval, input int fval);
        for (int i = 0; i < N; i++) xv[i] = xval;
        for (int j = 0; j < M; j++) fv[j] = fval;
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 200)) - 100;
        for (int j = 0; j < M; j++) fv[j] = int'($urandom_range(0, 200)) - 100;
    endtask

    // mode 0: both streams every cycle; 1: random gaps on both; 2: f starts after x completes.
    // Once a stream is complete its valid stays high with junk data, which must be ignored.
    task automatic load_vec(input int sel, input int mode, output int t_done);
        int xi = 0, fi = 0, budget = 0;
        bit ex, ef, fx, ff;
        t_done = 0;
        for (int i = 0; i < NOUT; i++) q.push_back(model(i, sel == 1));
        while ((xi < N || fi < M) && budget < 2000) begin
            @(negedge clk);
            budget++;
            case (mode)
                0:       begin ex = (xi < N); ef = (fi < M); end
                1:       begin ex = (xi < N) && ($urandom_range(0, 1) == 1);
                               ef = (fi < M) && ($urandom_range(0, 1) == 1); end
                default: begin ex = (xi < N) && ($urandom_range(0, 3) != 0);
                               ef = (fi < M) && (xi == N); end
            endcase
            vx[sel] = ex || (xi >= N);
            vf[sel] = ef || (fi >= M);
            dx[sel] = 20'sh5A5A5;
            df[sel] = 20'sh3C3C3;
            if (ex) dx[sel] = T'(xv[xi]);
            if (ef) df[sel] = T'(fv[fi]);
            fx = ex && rx[sel];
            ff = ef && rf[sel];
            if ((fx || ff) && (xi + int'(fx) == N) && (fi + int'(ff) == M)) t_done = cyc + 1;
            @(posedge clk);
            if (fx) xi++;
            if (ff) fi++;
        end
        check("load_done", (xi == N && fi == M), 1);
        @(negedge clk);
        check("ready_x_low_after_load", rx[sel], 0);
        check("ready_f_low_after_load", rf[sel], 0);
        check("valid_low_in_compute", vy[sel], 0);
    endtask

    task automatic collect(input int sel, input int n, input bit rand_rdy, output int t_last);
        int got = 0, budget = 0;
        bit stalled = 0;
        logic signed [T-1:0] held;
        logic signed [31:0]  exp;
        t_last = 0;
        held   = '0;
        while (got < n && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (stalled) begin
                check("stall_valid_held", vy[sel], 1);
                check("stall_data_held", y[sel], held);
            end
            ry[sel] = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            stalled = 0;
            if (vy[sel]) begin
                if (ry[sel]) begin
                    exp = 'x;
                    if (q.size() > 0) exp = q.pop_front();
                    check($sformatf("y_out%0d_lane%0d", sel, got), y[sel], exp);
                    got++;
                    t_last = cyc + 1;
                end else begin
                    stalled = 1;
                    held    = y[sel];
                end
            end
        end
        check("output_count", got, n);
        vx[sel] = 1'b0;
        vf[sel] = 1'b0;
        @(posedge clk);
        #1 ry[sel] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            dx[s] = '0; df[s] = '0; vx[s] = 1'b0; vf[s] = 1'b0; ry[s] = 1'b0;
        end
        set_const(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_x", rx[0], 0);
        check("rst_ready_f", rf[0], 0);
        check("rst_valid_y", vy[0], 0);
        check("rst_data_y", y[0], 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready_x", rx[0], 1);
        check("post_rst_ready_f", rf[0], 1);
        check("post_rst_ready_x_p3", rx[2], 1);

        // All ones: every output is 13, four groups of 2 lanes.
        set_const(1, 1);
        load_vec(0, 0, t0);
        collect(0, NOUT, 1'b0, tl);
        check("cycles_p2", tl - t0, 64);

        // Identity filter: y[i] = x[i].
        for (int i = 0; i < N; i++) xv[i] = i;
        for (int j = 0; j < M; j++) fv[j] = (j == 0) ? 1 : 0;
        load_vec(0, 1, t0);
        collect(0, NOUT, 1'b0, tl);

        // Positive and negative saturation; the second load finishes on the f stream.
        set_const(YMAX, YMAX);
        load_vec(0, 0, t0);
        collect(0, NOUT, 1'b0, tl);
        set_const(YMIN, YMAX);
        load_vec(0, 2, t0);
        collect(0, NOUT, 1'b0, tl);

        // ReLU instance: all results negative before clamping.
        set_const(1, -1);
        load_vec(1, 0, t0);
        collect(1, NOUT, 1'b0, tl);

        // Three lanes: groups of 3,3,2 -> (14+3)+(14+3)+(14+2) cycles; then the same
        // vector under random back-pressure must give the same values.
        set_random();
        load_vec(2, 0, t0);
        collect(2, NOUT, 1'b0, tl);
        check("cycles_p3", tl - t0, 50);
        load_vec(2, 1, t0);
        collect(2, NOUT, 1'b1, tl);

        // Abort in group 2 of COMPUTE; none of the remaining six results may appear.
        set_random();
        load_vec(0, 0, t0);
        collect(0, 2, 1'b0, tl);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_ready_x", rx[0], 0);
        check("midrun_rst_valid_y", vy[0], 0);
        check("midrun_rst_data_y", y[0], 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        #1;
        check("midrun_post_ready_x", rx[0], 1);
        check("midrun_post_ready_f", rf[0], 1);
        set_random();
        load_vec(0, 2, t0);
        collect(0, NOUT, 1'b1, tl);
        load_vec(0, 1, t0);
        collect(0, NOUT, 1'b0, tl);

        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
